// File: rtl/ws2812_pkg.sv
// ws2812_pkg: types and constants shared by the WS2812 receiver and transmitter.
// Holds the receiver state enum, the GRB field positions and the default timing.
package ws2812_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } rx_state_e;

  // Pixel layout on the wire: MSB first, green then red then blue
  localparam int PIXEL_BITS = 24;
  localparam int G_MSB      = 23;
  localparam int R_MSB      = 15;
  localparam int B_MSB      = 7;

  // Transmit timing, in clk cycles
  localparam int TICKS_0H   = 15;
  localparam int TICKS_0L   = 40;
  localparam int TICKS_1H   = 40;
  localparam int TICKS_1L   = 15;
  localparam int TICKS_RST  = 4000;

  // Receive classification, in clk cycles
  localparam int TICKS_THRESH = 28;
  localparam int TICKS_MIN    = 5;
  localparam int TICKS_MAX_H  = 80;
  localparam int IDX_W        = 10;

  typedef struct packed {
    logic [7:0] green;
    logic [7:0] red;
    logic [7:0] blue;
  } grb_t;

  // Split an assembled shift register into its colour fields
  function automatic grb_t unpack_grb(input logic [PIXEL_BITS-1:0] sr);
    grb_t p;
    p.green = sr[G_MSB -: 8];
    p.red   = sr[R_MSB -: 8];
    p.blue  = sr[B_MSB -: 8];
    return p;
  endfunction

endpackage

// File: rtl/ws2812_rx_if.sv
// ws2812_rx_if: decoded pixel/event bundle produced by ws2812_rx.
// master = the receiver driving it, slave = the consumer.
interface ws2812_rx_if #(
  parameter int IDX_W = 10
);
  logic [7:0]       red;
  logic [7:0]       green;
  logic [7:0]       blue;
  logic             valid;
  logic [IDX_W-1:0] pixel_idx;
  logic             frame_end;
  logic             err;

  modport master (output red, green, blue, valid, pixel_idx, frame_end, err);
  modport slave  (input  red, green, blue, valid, pixel_idx, frame_end, err);
endinterface

// File: rtl/ws2812_rx_sync.sv
// ws2812_rx_sync: 2-flop synchronizer for the asynchronous data line, followed
// by an edge register producing registered rise/fall strobes.
// chg flags a level change one cycle ahead of the rise/fall strobes.
module ws2812_rx_sync
  import ws2812_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic chg,
  output logic rise,
  output logic fall
);
  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Next values of the synchronizer chain and edge strobes
  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    prev_d = s2_q;
    rise_d = s2_q & ~prev_q;
    fall_d = ~s2_q & prev_q;
  end

  // Synchronizer and edge register flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign lvl  = s2_q;
  assign chg  = s2_q ^ prev_q;
  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 one-wire receiver. Classifies each high pulse by width,
// assembles 24-bit GRB pixels and detects the latch gap between frames.
// Optional macro WS2812_RX_FORWARD_EN: consume the first pixel of each frame
// and forward the rest of the frame on dout (cascade stage).
// Every output event lands 3 clk after the din edge / count expiry causing it:
// 2 sync flops + edge strobe register, then the registered outputs below.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int ticks_thresh = TICKS_THRESH,
  parameter int ticks_min    = TICKS_MIN,
  parameter int ticks_max_h  = TICKS_MAX_H,
  parameter int ticks_rst    = TICKS_RST,
  parameter int idx_w        = IDX_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            din,
  ws2812_rx_if.master     px,
  output logic            dout
);
  localparam int CW = $clog2(ticks_rst + 1);
  localparam logic [CW-1:0] THR_C  = CW'(ticks_thresh);
  localparam logic [CW-1:0] MIN_C  = CW'(ticks_min);
  localparam logic [CW-1:0] MAXH_C = CW'(ticks_max_h);
  localparam logic [CW-1:0] RST_C  = CW'(ticks_rst);

`ifdef WS2812_RX_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic lvl, chg, rise, fall;

  ws2812_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .lvl  (lvl),
    .chg  (chg),
    .rise (rise),
    .fall (fall)
  );

  rx_state_e              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic [CW-1:0]          wid_q, wid_d;
  logic [PIXEL_BITS-1:0]  sr_q, sr_d, sr_nxt;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [idx_w-1:0]       pix_q, pix_d, pix_inc;
  logic                   seen_q, seen_d;
  logic                   fwd_q, fwd_d;
  logic [7:0]             red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [idx_w-1:0]       idx_q, idx_d;
  logic                   valid_q, valid_d;
  logic                   fe_q, fe_d;
  logic                   err_q, err_d;
  logic                   shift_bit;
  grb_t                   px_nxt;

  // Width counter: restarts when the synchronized level changes, so it equals
  // the completed level width one cycle before the registered strobe.
  // wid_q keeps that width for the strobe cycle.
  always_comb begin
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    cnt_d   = cnt_inc;
    if (chg || (state_q == SYNC && lvl)) cnt_d = '0;
    wid_d   = chg ? cnt_inc : wid_q;
  end

  // Decoder FSM: next state, shift register, pixel/bit counters, output events
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    pix_d     = pix_q;
    seen_d    = seen_q;
    fwd_d     = fwd_q;
    red_d     = red_q;
    green_d   = green_q;
    blue_d    = blue_q;
    idx_d     = idx_q;
    valid_d   = 1'b0;
    fe_d      = 1'b0;
    err_d     = 1'b0;
    shift_bit = (wid_q >= THR_C);
    sr_nxt    = {sr_q[PIXEL_BITS-2:0], shift_bit};
    px_nxt    = unpack_grb(sr_nxt);
    pix_inc   = (pix_q == '1) ? pix_q : pix_q + 1'b1;

    case (state_q)
      SYNC: begin
        // Resync gap: no frame_end, nothing was trusted since the error
        if (cnt_q == RST_C) state_d = LOW;
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
        end else if (cnt_q == RST_C) begin
          // Latch gap; the counter runs past RST_C so this hits once per gap
          fe_d      = seen_q;
          err_d     = (bit_cnt_q != '0);
          bit_cnt_d = '0;
          pix_d     = '0;
          seen_d    = 1'b0;
          fwd_d     = 1'b0;
        end
      end
      HIGH: begin
        if (cnt_q >= MAXH_C) begin
          err_d     = 1'b1;
          state_d   = SYNC;
          bit_cnt_d = '0;
          pix_d     = '0;
          seen_d    = 1'b0;
          fwd_d     = 1'b0;
        end else if (fall) begin
          if (wid_q < MIN_C || wid_q >= MAXH_C) begin
            err_d     = 1'b1;
            state_d   = SYNC;
            bit_cnt_d = '0;
            pix_d     = '0;
            seen_d    = 1'b0;
            fwd_d     = 1'b0;
          end else begin
            sr_d    = sr_nxt;
            seen_d  = 1'b1;
            state_d = LOW;
            if (bit_cnt_q == 5'(PIXEL_BITS - 1)) begin
              bit_cnt_d = '0;
              pix_d     = pix_inc;
              fwd_d     = FWD_EN;
              // A cascade stage only reports the pixel it consumes
              if (!FWD_EN || pix_q == '0) begin
                valid_d = 1'b1;
                red_d   = px_nxt.red;
                green_d = px_nxt.green;
                blue_d  = px_nxt.blue;
                idx_d   = pix_q;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SYNC;
      cnt_q     <= '0;
      wid_q     <= '0;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      pix_q     <= '0;
      seen_q    <= 1'b0;
      fwd_q     <= 1'b0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wid_q     <= wid_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      pix_q     <= pix_d;
      seen_q    <= seen_d;
      fwd_q     <= fwd_d;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      err_q     <= err_d;
    end
  end

  assign px.red       = red_q;
  assign px.green     = green_q;
  assign px.blue      = blue_q;
  assign px.pixel_idx = idx_q;
  assign px.valid     = valid_q;
  assign px.frame_end = fe_q;
  assign px.err       = err_q;

  // Forwarding passes the synchronized line, held low until pixel 0 is consumed
  assign dout = FWD_EN & fwd_q & lvl;
endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: directed bench for ws2812_rx. Generates WS2812 waveforms with
// the transmitter timing and checks decoded pixels, event timing and errors.
module tb_ws2812_rx;
  import ws2812_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic dout;

  ws2812_rx_if #(.IDX_W(10)) px ();

  ws2812_rx dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .px   (px),
    .dout (dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [7:0] g, r, b;
    logic [9:0] idx;
  } vrec_t;

  vrec_t vq[$];
  int fe_n = 0, fe_cyc = 0, err_n = 0, err_cyc = 0, dout_bad = 0;
  int n_vec = 0, n_bad = 0, last_fall = 0;
  bit fwd_phase = 1'b0;
  logic [1:0] hist = 2'b00;

  // din as seen after the 2-flop synchronizer
  always @(posedge clk) hist <= {hist[0], din};

  // Event log sampled away from the active edge
  always @(negedge clk) begin
    if (px.valid) vq.push_back('{c: cyc, g: px.green, r: px.red, b: px.blue, idx: px.pixel_idx});
    if (px.frame_end) begin fe_n++; fe_cyc = cyc; end
    if (px.err) begin err_n++; err_cyc = cyc; end
    if (!rst && dout !== (fwd_phase ? hist[1] : 1'b0)) dout_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit b);
    din = 1'b1;
    idle(b ? TICKS_1H : TICKS_0H);
    din = 1'b0;
    last_fall = cyc + 1;
    idle(b ? TICKS_1L : TICKS_0L);
  endtask

  task automatic send_bits(input logic [23:0] p, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(p[i]);
  endtask

  task automatic clr_log();
    vq.delete();
    fe_n  = 0;
    err_n = 0;
  endtask

  task automatic chk_pix(input string tag, input int k, input logic [23:0] p, input int idx, input int fall);
    if (k >= vq.size()) begin
      chk({tag, "_cnt"}, vq.size(), k + 1);
      return;
    end
    chk({tag, "_g"},   vq[k].g, p[23:16]);
    chk({tag, "_r"},   vq[k].r, p[15:8]);
    chk({tag, "_b"},   vq[k].b, p[7:0]);
    chk({tag, "_idx"}, vq[k].idx, idx);
    chk({tag, "_lat"}, vq[k].c, fall + 3);
  endtask

  int f[3];
  int t;

  initial begin
    // Reset state
    idle(3);
    chk("rst_grb",   {px.green, px.red, px.blue}, 24'h0);
    chk("rst_valid", px.valid, 0);
    chk("rst_idx",   px.pixel_idx, 0);
    chk("rst_fe",    px.frame_end, 0);
    chk("rst_err",   px.err, 0);
    chk("rst_dout",  dout, 0);
    chk("rst_state", 32'(dut.state_q), 32'(SYNC));
    rst = 1'b0;
    idle(4100);

    // Single pixel then latch gap
    clr_log();
    send_bits(24'h123456, 24);
    f[0] = last_fall;
    idle(20);
    chk("p1_n", vq.size(), 1);
    chk_pix("p1", 0, 24'h123456, 0, f[0]);
    idle(4100);
    chk("p1_fe_n",   fe_n, 1);
    chk("p1_fe_cyc", fe_cyc, f[0] + 4003);
    chk("p1_err_n",  err_n, 0);

`ifdef WS2812_RX_FORWARD_EN
    // Cascade: first pixel consumed, second forwarded on dout
    clr_log();
    send_bits(24'h0102FF, 24);
    f[0] = last_fall;
    fwd_phase = 1'b1;
    send_bits(24'hF0550A, 24);
    idle(20);
    chk("fw_n", vq.size(), 1);
    chk_pix("fw", 0, 24'h0102FF, 0, f[0]);
    idle(4100);
    fwd_phase = 1'b0;
    chk("fw_fe_n",  fe_n, 1);
    chk("fw_err_n", err_n, 0);
`else
    // Three pixels back to back
    clr_log();
    send_bits(24'hFF0080, 24); f[0] = last_fall;
    send_bits(24'h00FF01, 24); f[1] = last_fall;
    send_bits(24'h7E817E, 24); f[2] = last_fall;
    idle(20);
    chk("p3_n", vq.size(), 3);
    chk_pix("p3a", 0, 24'hFF0080, 0, f[0]);
    chk_pix("p3b", 1, 24'h00FF01, 1, f[1]);
    chk_pix("p3c", 2, 24'h7E817E, 2, f[2]);
    idle(4100);
    chk("p3_fe_n",   fe_n, 1);
    chk("p3_fe_cyc", fe_cyc, f[2] + 4003);
    chk("p3_err_n",  err_n, 0);

    // Partial pixel (10 bits) then gap: err and frame_end together
    clr_log();
    send_bits(24'h0002AB, 10);
    f[0] = last_fall;
    idle(4100);
    chk("pp_err_n",   err_n, 1);
    chk("pp_fe_n",    fe_n, 1);
    chk("pp_err_cyc", err_cyc, f[0] + 4003);
    chk("pp_fe_cyc",  fe_cyc, f[0] + 4003);
    chk("pp_valid_n", vq.size(), 0);
    clr_log();
    send_bits(24'hABCDEF, 24);
    f[0] = last_fall;
    idle(20);
    chk_pix("pp_next", 0, 24'hABCDEF, 0, f[0]);
    idle(4100);
    chk("pp_next_fe", fe_n, 1);

    // Short glitch mid-pixel
    clr_log();
    send_bits(24'h00005A, 8);
    din = 1'b1;
    idle(3);
    din = 1'b0;
    t = cyc + 1;
    idle(40);
    chk("gl_err_n",   err_n, 1);
    chk("gl_err_cyc", err_cyc, t + 3);
    send_bits(24'h00C3A5, 16);
    idle(4100);
    chk("gl_valid_n", vq.size(), 0);
    chk("gl_fe_n",    fe_n, 0);
    clr_log();
    send_bits(24'h0F1E2D, 24);
    f[0] = last_fall;
    idle(20);
    chk_pix("gl_next", 0, 24'h0F1E2D, 0, f[0]);
    idle(4100);
    chk("gl_next_fe", fe_n, 1);

    // Stuck high
    clr_log();
    din = 1'b1;
    t = cyc + 1;
    idle(200);
    chk("sh_err_n",   err_n, 1);
    chk("sh_err_cyc", err_cyc, t + 83);
    chk("sh_state",   32'(dut.state_q), 32'(SYNC));
    din = 1'b0;
    idle(4100);
    chk("sh_fe_n", fe_n, 0);
    clr_log();
    send_bits(24'h804020, 24);
    f[0] = last_fall;
    idle(20);
    chk_pix("sh_next", 0, 24'h804020, 0, f[0]);

    // Asynchronous reset at bit 12
    clr_log();
    send_bits(24'h000FFF, 12);
    rst = 1'b1;
    #1;
    chk("ar_grb",   {px.green, px.red, px.blue}, 24'h0);
    chk("ar_valid", px.valid, 0);
    chk("ar_idx",   px.pixel_idx, 0);
    chk("ar_state", 32'(dut.state_q), 32'(SYNC));
    @(negedge clk);
    rst = 1'b0;
    send_bits(24'h112233, 24);
    idle(4100);
    chk("ar_valid_n", vq.size(), 0);
    chk("ar_fe_n",    fe_n, 0);
    chk("ar_err_n",   err_n, 0);
    clr_log();
    send_bits(24'h445566, 24);
    f[0] = last_fall;
    idle(20);
    chk_pix("ar_next", 0, 24'h445566, 0, f[0]);
    idle(4100);
    chk("ar_next_fe", fe_n, 1);
`endif

    chk("dout_bad", dout_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
